// File: rtl/decode_stage_hz.sv
// decode_stage_hz: instruction decode stage with register file, load-use
// hazard detection and a saturating stall counter.
//
// Ports:
//   i_clock, i_reset        clock, synchronous active-high reset
//   i_valid                 pipeline advance enable (low freezes all state)
//   i_flush                 squash the instruction being decoded
//   i_instruction/i_pc_next fetched instruction and its PC+1
//   i_wb_enable/sel/data    register write-back port
//   i_ex_mem_read/i_ex_rt   load currently in EX and its destination
//   o_stall                 combinational load-use hazard indication
//   o_valid_out ... o_instruction_index   registered ID/EX payload
//   o_stall_count           saturating count of stall cycles
module decode_stage_hz #(
  parameter int unsigned NB_DATA      = 32,
  parameter int unsigned NB_REGISTER  = 5,
  parameter int unsigned N_REGISTERS  = 32,
  parameter int unsigned NB_STALL_CNT = 16
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_valid,
  input  logic                    i_flush,
  input  logic [NB_DATA-1:0]      i_instruction,
  input  logic [NB_DATA-1:0]      i_pc_next,
  input  logic                    i_wb_enable,
  input  logic [NB_REGISTER-1:0]  i_wb_sel,
  input  logic [NB_DATA-1:0]      i_wb_data,
  input  logic                    i_ex_mem_read,
  input  logic [NB_REGISTER-1:0]  i_ex_rt,
  output logic                    o_stall,
  output logic                    o_valid_out,
  output logic [5:0]              o_opcode,
  output logic [5:0]              o_funct,
  output logic [NB_REGISTER-1:0]  o_rs,
  output logic [NB_REGISTER-1:0]  o_rt,
  output logic [NB_REGISTER-1:0]  o_rd,
  output logic [NB_REGISTER-1:0]  o_sa,
  output logic [NB_DATA-1:0]      o_pc_next,
  output logic [NB_DATA-1:0]      o_data_read_reg_0,
  output logic [NB_DATA-1:0]      o_data_read_reg_1,
  output logic [NB_DATA-1:0]      o_extended,
  output logic [25:0]             o_instruction_index,
  output logic [NB_STALL_CNT-1:0] o_stall_count
);

  localparam int unsigned NB_IMM = 16;
  localparam int unsigned NB_SEL = NB_REGISTER + 1;
  localparam logic [5:0]  OP_ANDI = 6'h0C;
  localparam logic [5:0]  OP_ORI  = 6'h0D;
  localparam logic [5:0]  OP_XORI = 6'h0E;

  // Register 0 is hardwired to zero, so it has no storage.
  logic [NB_DATA-1:0] rf [1:N_REGISTERS-1];

  logic [5:0]             opcode;
  logic [5:0]             funct;
  logic [NB_REGISTER-1:0] rs, rt, rd, sa;
  logic [NB_IMM-1:0]      imm;
  logic [NB_DATA-1:0]     read_0, read_1, extended;
  logic                   wr_en;
  logic                   bubble;

  // Instruction field extraction.
  assign opcode = i_instruction[31:26];
  assign rs     = NB_REGISTER'(i_instruction[25:21]);
  assign rt     = NB_REGISTER'(i_instruction[20:16]);
  assign rd     = NB_REGISTER'(i_instruction[15:11]);
  assign sa     = NB_REGISTER'(i_instruction[10:6]);
  assign funct  = i_instruction[5:0];
  assign imm    = i_instruction[15:0];

  // Write-back qualifies on pipeline advance; r0 and out-of-range selects drop.
  assign wr_en = i_valid & i_wb_enable & (i_wb_sel != '0) &
                 ({1'b0, i_wb_sel} < NB_SEL'(N_REGISTERS));

  // Load-use hazard against the instruction being decoded.
  assign o_stall = i_ex_mem_read & (i_ex_rt != '0) &
                   ((i_ex_rt == rs) | (i_ex_rt == rt));

  assign bubble = i_flush | o_stall;

  // Logical immediates zero-extend, everything else sign-extends.
  always_comb begin
    extended = {{(NB_DATA-NB_IMM){imm[NB_IMM-1]}}, imm};
    if (opcode == OP_ANDI || opcode == OP_ORI || opcode == OP_XORI)
      extended = NB_DATA'(imm);
  end

  // Operand read with same-cycle write-back forwarding.
  always_comb begin
    read_0 = '0;
    read_1 = '0;
    for (int i = 1; i < int'(N_REGISTERS); i++) begin
      if (rs == NB_REGISTER'(i)) read_0 = rf[i];
      if (rt == NB_REGISTER'(i)) read_1 = rf[i];
    end
    if (wr_en && i_wb_sel == rs) read_0 = i_wb_data;
    if (wr_en && i_wb_sel == rt) read_1 = i_wb_data;
  end

  // Register file storage.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int i = 1; i < int'(N_REGISTERS); i++) rf[i] <= '0;
    end else if (wr_en) begin
      for (int i = 1; i < int'(N_REGISTERS); i++)
        if (i_wb_sel == NB_REGISTER'(i)) rf[i] <= i_wb_data;
    end
  end

  // ID/EX pipeline register; flush and stall both load an all-zero bubble.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_valid_out         <= 1'b0;
      o_opcode            <= '0;
      o_funct             <= '0;
      o_rs                <= '0;
      o_rt                <= '0;
      o_rd                <= '0;
      o_sa                <= '0;
      o_pc_next           <= '0;
      o_data_read_reg_0   <= '0;
      o_data_read_reg_1   <= '0;
      o_extended          <= '0;
      o_instruction_index <= '0;
      o_stall_count       <= '0;
    end else if (i_valid) begin
      o_valid_out         <= ~bubble;
      o_opcode            <= bubble ? '0 : opcode;
      o_funct             <= bubble ? '0 : funct;
      o_rs                <= bubble ? '0 : rs;
      o_rt                <= bubble ? '0 : rt;
      o_rd                <= bubble ? '0 : rd;
      o_sa                <= bubble ? '0 : sa;
      o_pc_next           <= bubble ? '0 : i_pc_next;
      o_data_read_reg_0   <= bubble ? '0 : read_0;
      o_data_read_reg_1   <= bubble ? '0 : read_1;
      o_extended          <= bubble ? '0 : extended;
      o_instruction_index <= bubble ? '0 : i_instruction[25:0];
      // Flush takes priority, so a flushed stall is not counted.
      if (!i_flush && o_stall && o_stall_count != '1)
        o_stall_count <= o_stall_count + NB_STALL_CNT'(1);
    end
  end

endmodule

// File: tb/tb_decode_stage_hz.sv
// tb_decode_stage_hz: directed self-checking bench for decode_stage_hz.
// A second instance with a 2-bit stall counter and 16 registers covers
// counter saturation and out-of-range write-back selects.
module tb_decode_stage_hz;

  logic        i_clock = 1'b0;
  logic        i_reset, i_valid, i_flush;
  logic [31:0] i_instruction, i_pc_next, i_wb_data;
  logic        i_wb_enable, i_ex_mem_read;
  logic [4:0]  i_wb_sel, i_ex_rt;

  logic        stall, valid_out;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, sa;
  logic [31:0] pc_next, rd0, rd1, ext;
  logic [25:0] idx;
  logic [15:0] cnt;

  logic        s_stall, s_valid_out;
  logic [5:0]  s_opcode, s_funct;
  logic [4:0]  s_rs, s_rt, s_rd, s_sa;
  logic [31:0] s_pc_next, s_rd0, s_rd1, s_ext;
  logic [25:0] s_idx;
  logic [1:0]  s_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 i_clock = ~i_clock;

  decode_stage_hz dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_valid(i_valid), .i_flush(i_flush),
    .i_instruction(i_instruction), .i_pc_next(i_pc_next),
    .i_wb_enable(i_wb_enable), .i_wb_sel(i_wb_sel), .i_wb_data(i_wb_data),
    .i_ex_mem_read(i_ex_mem_read), .i_ex_rt(i_ex_rt),
    .o_stall(stall), .o_valid_out(valid_out), .o_opcode(opcode), .o_funct(funct),
    .o_rs(rs), .o_rt(rt), .o_rd(rd), .o_sa(sa), .o_pc_next(pc_next),
    .o_data_read_reg_0(rd0), .o_data_read_reg_1(rd1), .o_extended(ext),
    .o_instruction_index(idx), .o_stall_count(cnt)
  );

  decode_stage_hz #(.N_REGISTERS(16), .NB_STALL_CNT(2)) dut_small (
    .i_clock(i_clock), .i_reset(i_reset), .i_valid(i_valid), .i_flush(i_flush),
    .i_instruction(i_instruction), .i_pc_next(i_pc_next),
    .i_wb_enable(i_wb_enable), .i_wb_sel(i_wb_sel), .i_wb_data(i_wb_data),
    .i_ex_mem_read(i_ex_mem_read), .i_ex_rt(i_ex_rt),
    .o_stall(s_stall), .o_valid_out(s_valid_out), .o_opcode(s_opcode), .o_funct(s_funct),
    .o_rs(s_rs), .o_rt(s_rt), .o_rd(s_rd), .o_sa(s_sa), .o_pc_next(s_pc_next),
    .o_data_read_reg_0(s_rd0), .o_data_read_reg_1(s_rd1), .o_extended(s_ext),
    .o_instruction_index(s_idx), .o_stall_count(s_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  function automatic logic [31:0] r_type(input logic [4:0] f_rs, input logic [4:0] f_rt,
                                         input logic [4:0] f_rd, input logic [5:0] f_funct);
    return {6'h00, f_rs, f_rt, f_rd, 5'd0, f_funct};
  endfunction

  function automatic logic [31:0] i_type(input logic [5:0] f_op, input logic [4:0] f_rs,
                                         input logic [4:0] f_rt, input logic [15:0] f_imm);
    return {f_op, f_rs, f_rt, f_imm};
  endfunction

  task automatic wb(input logic en, input logic [4:0] sel, input logic [31:0] data);
    i_wb_enable = en;
    i_wb_sel    = sel;
    i_wb_data   = data;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    i_reset = 1'b1; i_valid = 1'b0; i_flush = 1'b0;
    i_instruction = '0; i_pc_next = '0;
    wb(1'b0, 5'd0, '0);
    i_ex_mem_read = 1'b0; i_ex_rt = '0;

    // Reset with i_valid low still clears.
    tick(); tick();
    check("rst_valid", 32'(valid_out), 32'd0);
    check("rst_cnt", 32'(cnt), 32'd0);
    check("rst_pc", pc_next, 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    i_reset = 1'b0; i_valid = 1'b1;

    // Write r5 then decode ADD rs=5 rt=0 rd=1.
    wb(1'b1, 5'd5, 32'h1234);
    tick();
    wb(1'b0, 5'd0, '0);
    i_instruction = r_type(5'd5, 5'd0, 5'd1, 6'h20);
    i_pc_next = 32'h10;
    tick();
    check("add_rd0", rd0, 32'h1234);
    check("add_rd1", rd1, 32'h0);
    check("add_valid", 32'(valid_out), 32'd1);
    check("add_funct", 32'(funct), 32'h20);
    check("add_rs", 32'(rs), 32'd5);
    check("add_rd", 32'(rd), 32'd1);
    check("add_pc", pc_next, 32'h10);
    check("add_ext", ext, 32'h0000_0820);
    check("add_idx", 32'(idx), 32'h00A0_0820);

    // Same-cycle write of r7 forwarded into the rs read.
    wb(1'b1, 5'd7, 32'hCAFE);
    i_instruction = r_type(5'd7, 5'd5, 5'd2, 6'h20);
    i_pc_next = 32'h14;
    tick();
    check("byp_rd0", rd0, 32'hCAFE);
    check("byp_rd1", rd1, 32'h1234);

    // Write to r0 is discarded.
    wb(1'b1, 5'd0, 32'hFFFF);
    i_instruction = r_type(5'd0, 5'd0, 5'd3, 6'h20);
    tick();
    check("r0_byp", rd0, 32'h0);
    wb(1'b0, 5'd0, '0);
    tick();
    check("r0_read", rd0, 32'h0);

    // No hazard against r0 even for a load.
    i_ex_mem_read = 1'b1; i_ex_rt = 5'd0;
    #1;
    check("stall_r0", 32'(stall), 32'd0);

    // Load-use stall for two cycles; write r3 during the first.
    i_ex_rt = 5'd3;
    i_instruction = r_type(5'd1, 5'd3, 5'd4, 6'h20);
    i_pc_next = 32'h20;
    wb(1'b1, 5'd3, 32'h55);
    #1;
    check("stall_c1", 32'(stall), 32'd1);
    tick();
    wb(1'b0, 5'd0, '0);
    check("bub1_valid", 32'(valid_out), 32'd0);
    check("bub1_pc", pc_next, 32'd0);
    check("bub1_rs", 32'(rs), 32'd0);
    check("bub1_cnt", 32'(cnt), 32'd1);
    check("stall_c2", 32'(stall), 32'd1);
    tick();
    check("bub2_valid", 32'(valid_out), 32'd0);
    check("bub2_cnt", 32'(cnt), 32'd2);
    i_ex_mem_read = 1'b0;
    #1;
    check("stall_c3", 32'(stall), 32'd0);
    tick();
    check("cap_valid", 32'(valid_out), 32'd1);
    check("cap_rt", 32'(rt), 32'd3);
    check("cap_rd1", rd1, 32'h55);
    check("cap_pc", pc_next, 32'h20);
    check("cap_cnt", 32'(cnt), 32'd2);

    // Immediate extension.
    i_instruction = i_type(6'h0D, 5'd0, 5'd2, 16'h8000);
    tick();
    check("ori_ext", ext, 32'h0000_8000);
    check("ori_op", 32'(opcode), 32'h0D);
    i_instruction = i_type(6'h08, 5'd0, 5'd2, 16'h8000);
    tick();
    check("addi_ext", ext, 32'hFFFF_8000);
    i_instruction = i_type(6'h0C, 5'd0, 5'd2, 16'hFFFF);
    tick();
    check("andi_ext", ext, 32'h0000_FFFF);
    i_instruction = i_type(6'h0E, 5'd0, 5'd2, 16'h8001);
    tick();
    check("xori_ext", ext, 32'h0000_8001);

    // Flush overrides a stall: bubble, count unchanged, write still lands.
    i_ex_mem_read = 1'b1; i_ex_rt = 5'd3;
    i_instruction = r_type(5'd3, 5'd3, 5'd4, 6'h20);
    i_pc_next = 32'h30;
    i_flush = 1'b1;
    wb(1'b1, 5'd9, 32'h99);
    tick();
    check("fl_valid", 32'(valid_out), 32'd0);
    check("fl_pc", pc_next, 32'd0);
    check("fl_cnt", 32'(cnt), 32'd2);
    i_flush = 1'b0; i_ex_mem_read = 1'b0;
    wb(1'b0, 5'd0, '0);

    // Capture a known instruction, then freeze for three cycles.
    i_instruction = r_type(5'd7, 5'd9, 5'd6, 6'h22);
    i_pc_next = 32'h40;
    tick();
    check("pre_rd1", rd1, 32'h99);
    i_valid = 1'b0;
    i_instruction = r_type(5'd3, 5'd3, 5'd8, 6'h24);
    i_pc_next = 32'h44;
    i_ex_mem_read = 1'b1; i_ex_rt = 5'd3;
    wb(1'b1, 5'd7, 32'hDEAD);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("frz_rd0", rd0, 32'hCAFE);
      check("frz_pc", pc_next, 32'h40);
      check("frz_valid", 32'(valid_out), 32'd1);
      check("frz_cnt", 32'(cnt), 32'd2);
    end
    i_valid = 1'b1; i_ex_mem_read = 1'b0;
    wb(1'b0, 5'd0, '0);
    i_instruction = r_type(5'd7, 5'd9, 5'd6, 6'h22);
    tick();
    check("frz_nowr", rd0, 32'hCAFE);

    // Reset in the middle of a stall.
    i_ex_mem_read = 1'b1; i_ex_rt = 5'd9;
    tick();
    check("mid_cnt", 32'(cnt), 32'd3);
    i_reset = 1'b1;
    tick();
    check("mrst_valid", 32'(valid_out), 32'd0);
    check("mrst_cnt", 32'(cnt), 32'd0);
    i_reset = 1'b0; i_ex_mem_read = 1'b0;
    tick();
    check("mrst_rf", rd0, 32'h0);

    // Out-of-range write-back select ignored by the 16-register instance.
    wb(1'b1, 5'd20, 32'h77);
    i_instruction = r_type(5'd0, 5'd0, 5'd0, 6'h00);
    tick();
    wb(1'b0, 5'd0, '0);
    i_instruction = r_type(5'd20, 5'd0, 5'd0, 6'h20);
    tick();
    check("sel20_big", rd0, 32'h77);
    check("sel20_small", s_rd0, 32'h0);

    // Counter saturation on the 2-bit instance.
    i_ex_mem_read = 1'b1; i_ex_rt = 5'd3;
    i_instruction = r_type(5'd1, 5'd3, 5'd4, 6'h20);
    for (int k = 1; k <= 5; k++) begin
      tick();
      check("sat_small", 32'(s_cnt), (k > 3) ? 32'd3 : 32'(k));
    end
    check("sat_big", 32'(cnt), 32'd5);
    i_ex_mem_read = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/decode_stage_hz.md
DECODE_STAGE_HZ -- requirements
Module: decode_stage_hz

Interface
REQ-001 The block SHALL take parameter NB_DATA, default 32, as the datapath width.
REQ-002 The block SHALL take parameter NB_REGISTER, default 5, as the register-select width.
REQ-003 The block SHALL take parameter N_REGISTERS, default 32, as the register count; N_REGISTERS <= 2**NB_REGISTER.
REQ-004 The block SHALL take parameter NB_STALL_CNT, default 16, as the stall-counter width.
REQ-005 The block SHALL provide these ports:
- i_clock  in  1  clock; all state changes on the rising edge
- i_reset  in  1  synchronous, active-high reset
- i_valid  in  1  pipeline advance enable; low freezes all state
- i_flush  in  1  squash the instruction currently being decoded
- i_instruction  in  NB_DATA  fetched instruction
- i_pc_next  in  NB_DATA  PC+1 of the fetched instruction
- i_wb_enable  in  1  write-back request
- i_wb_sel  in  NB_REGISTER  write-back register
- i_wb_data  in  NB_DATA  write-back data
- i_ex_mem_read  in  1  instruction in EX is a load
- i_ex_rt  in  NB_REGISTER  destination register of the EX load
- o_stall  out  1  load-use hazard; IF holds PC and instruction
- o_valid_out  out  1  ID/EX outputs hold a real instruction
- o_opcode  out  6  instruction[31:26]
- o_funct  out  6  instruction[5:0]
- o_rs, o_rt, o_rd, o_sa  out  NB_REGISTER each  fields [25:21], [20:16], [15:11], [10:6]
- o_pc_next  out  NB_DATA  registered PC+1
- o_data_read_reg_0, o_data_read_reg_1  out  NB_DATA each  rs and rt operand values
- o_extended  out  NB_DATA  extended immediate
- o_instruction_index  out  26  instruction[25:0]
- o_stall_count  out  NB_STALL_CNT  saturating count of stall cycles

Function
REQ-006 Register file: N_REGISTERS x NB_DATA; register 0 reads 0 and ignores writes.
REQ-007 Register writes SHALL occur on the rising edge when i_valid=1, i_wb_enable=1 and i_wb_sel!=0; i_wb_sel >= N_REGISTERS SHALL be ignored.
REQ-008 Register reads SHALL be combinational from i_instruction rs/rt; a same-cycle write to that register SHALL bypass i_wb_data into the read value.
REQ-009 Hazard detection: o_stall = i_ex_mem_read & (i_ex_rt!=0) & (i_ex_rt==rs | i_ex_rt==rt), combinational, fields taken from i_instruction.
REQ-010 ID/EX register update priority, highest first: reset; i_valid=0 (hold everything); i_flush; o_stall; normal capture.
REQ-011 i_flush=1 with i_valid=1 SHALL load a bubble: o_valid_out=0 and every other output 0, register writes still performed; flush SHALL override stall.
REQ-012 o_stall=1 with i_valid=1 SHALL load the same bubble and increment o_stall_count.
REQ-013 Normal capture SHALL register all decoded fields, operands and i_pc_next, and set o_valid_out=1; latency 1 cycle.
REQ-014 o_extended SHALL zero-extend instruction[15:0] for opcodes 0x0C, 0x0D, 0x0E (ANDI/ORI/XORI) and sign-extend it otherwise.
REQ-015 o_stall_count SHALL saturate at all-ones and never wrap.
REQ-016 A stall SHALL persist each cycle the condition holds; no cycle limit.

Reset
REQ-017 i_reset=1 at a rising edge SHALL clear all outputs, o_stall_count and every register-file entry to 0, regardless of i_valid.
REQ-018 Reset mid-stall SHALL produce o_valid_out=0 and o_stall_count=0 on the next cycle.

Verification
REQ-019 The bench SHALL cover these scenarios:
- Write r5=0x1234, then decode ADD rs=5 rt=0 -> next cycle o_data_read_reg_0=0x1234, o_valid_out=1.
- Same-cycle write r7=0xCAFE while decoding rs=7 -> o_data_read_reg_0=0xCAFE.
- Write r0=0xFFFF, read rs=0 -> 0.
- i_ex_mem_read=1, i_ex_rt=3, instruction rt=3 for 2 cycles -> o_stall=1 both cycles, two bubbles, o_stall_count=2; third cycle captured.
- ORI imm 0x8000 -> o_extended=0x00008000; ADDI imm 0x8000 -> 0xFFFF8000.
- Stall and i_flush together -> bubble, o_stall_count unchanged.
- i_valid=0 for 3 cycles -> outputs and registers frozen.
- Preload count all-ones, then stall -> count stays all-ones.
